// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped countdown timer:
// register map, CTRL layout, FSM states and the byte-lane merge helper.
package tc_pkg;

    localparam logic [1:0] CTRL_IDX   = 2'd0;
    localparam logic [1:0] PRESET_IDX = 2'd1;
    localparam logic [1:0] COUNT_IDX  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tc_state_e;

    // Replace each enabled byte lane of old with the matching lane of wdata.
    function automatic logic [31:0] be_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  byteen);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = byteen[i] ? wdata[i*8 +: 8] : old[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/tc_timer.sv
// Countdown timer on the CPU data bus: CTRL/PRESET/COUNT registers, a
// load/count/interrupt FSM and a registered interrupt output.
module tc_timer
    import tc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q, count_d;
    tc_state_e         state_q, state_d;
    logic              irq_flag_q, irq_flag_d;

    logic              sel;
    logic [1:0]        reg_idx;
    logic              wr_ctrl;
    logic              wr_preset;
    logic              ctrl_en;
    logic [1:0]        ctrl_mode;
    logic [CTRL_W-1:0] ctrl_fsm;
    logic [CTRL_W-1:0] ctrl_merged;
    logic [31-CTRL_W:0] unused_ctrl_hi;
    logic              unused_addr_lsb;

    assign sel             = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx         = addr[3:2];
    assign wr_ctrl         = sel && (byteen != 4'b0) && (reg_idx == CTRL_IDX);
    assign wr_preset       = sel && (byteen != 4'b0) && (reg_idx == PRESET_IDX);
    assign ctrl_en         = ctrl_q[CTRL_EN];
    assign ctrl_mode       = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
    assign unused_addr_lsb = ^addr[1:0];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ctrl_fsm   = ctrl_q;
        irq_flag_d = irq_flag_q;

        // A bus write clears the flag; an interrupt raised on the same edge still wins.
        if (wr_ctrl || wr_preset) begin
            irq_flag_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ctrl_en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_en) begin
                    state_d = IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                case (ctrl_mode)
                    MODE_AUTO: begin
                        irq_flag_d = 1'b0;
                        state_d    = LOAD;
                    end
                    MODE_ONESHOT: begin
                        ctrl_fsm[CTRL_EN] = 1'b0;
                        state_d           = IDLE;
                    end
                    default: begin
                        ctrl_fsm[CTRL_EN] = 1'b0;
                        state_d           = IDLE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // The bus write is merged on top of the FSM's EN clear so software wins a collision.
    always_comb begin
        {unused_ctrl_hi, ctrl_merged} = be_merge(32'(ctrl_fsm), wdata, byteen);
        ctrl_d   = wr_ctrl ? ctrl_merged : ctrl_fsm;
        preset_d = wr_preset ? CNT_W'(be_merge(32'(preset_q), wdata, byteen)) : preset_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            irq_flag_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_idx)
                CTRL_IDX:   rdata = 32'(ctrl_q);
                PRESET_IDX: rdata = 32'(preset_q);
                COUNT_IDX:  rdata = 32'(count_q);
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_tc_timer.sv
// Self-checking bench for tc_timer: directed register/timing cases plus
// randomized timer runs checked against a timeline model of the counter.
module tb_tc_timer;

    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_PRESET = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Reference copies of the software-visible registers.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;

    tc_timer dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] be);
        if (a == A_CTRL && be[0]) m_ctrl = d[3:0];
        if (a == A_PRESET) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) m_preset[i*8 +: 8] = d[i*8 +: 8];
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        addr   = a;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        #1;
        addr   = '0;
        wdata  = '0;
        byteen = '0;
        model_write(a, d, be);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr   = a;
        byteen = '0;
        #1;
        d    = rdata;
        addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        m_ctrl   = '0;
        m_preset = '0;
    endtask

    // Runs K edges after the edge that wrote EN=1. The counter is modelled as a
    // timeline: a load 2 edges after enable, COUNT = preset - elapsed (floored at 0),
    // interrupt max(preset,1) edges after a load, next load 2 edges after that.
    task automatic check_run(input int k_max, input int prev_cnt, input logic im,
                             input logic auto_m, input int mid_k, input logic [31:0] mid_val);
        int          next_load;
        int          load_k;
        int          n_cur;
        int          int_k;
        int          diff;
        logic [31:0] got;
        logic [31:0] exp_cnt;
        logic        exp_flag;
        next_load = 2;
        load_k    = -1;
        n_cur     = 0;
        int_k     = -1;
        for (int k = 1; k <= k_max; k++) begin
            if (k == next_load) begin
                load_k    = k;
                n_cur     = int'(m_preset);
                int_k     = k + ((n_cur < 1) ? 1 : n_cur);
                next_load = auto_m ? int_k + 2 : -1;
            end
            if (k == mid_k) bus_write(A_PRESET, mid_val, 4'hF);
            else tick();
            if (!auto_m && k == int_k + 1) m_ctrl[0] = 1'b0;
            if (load_k < 0) begin
                exp_cnt = 32'(prev_cnt);
            end else begin
                diff    = n_cur - (k - load_k);
                exp_cnt = (diff > 0) ? 32'(diff) : 32'd0;
            end
            exp_flag = auto_m ? (k == int_k) : (int_k > 0 && k >= int_k);
            bus_read(A_COUNT, got);
            check_eq("count", got, exp_cnt);
            check_eq("irq", 32'(irq), 32'(exp_flag & im));
        end
        bus_read(A_CTRL, got);
        check_eq("ctrl_after_run", got, 32'(m_ctrl));
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] junk;
        int          n;
        int          mode;
        int          im;
        int          mid_k;
        int          mid_val;
        logic        auto_m;

        reset    = 1'b0;
        addr     = '0;
        byteen   = '0;
        wdata    = '0;
        m_ctrl   = '0;
        m_preset = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset defaults
        bus_read(A_CTRL, got);   check_eq("rst_ctrl", got, 32'h0);
        bus_read(A_PRESET, got); check_eq("rst_preset", got, 32'h0);
        bus_read(A_COUNT, got);  check_eq("rst_count", got, 32'h0);
        bus_read(A_RSVD, got);   check_eq("rst_rsvd", got, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        bus_read(32'h0000_7E00, got); check_eq("rst_outside", got, 32'h0);

        // Byte-enable merge and ignored writes
        bus_write(A_PRESET, 32'h1122_3344, 4'hF);
        bus_write(A_PRESET, 32'hAABB_CCDD, 4'b1000);
        bus_read(A_PRESET, got); check_eq("be_merge", got, m_preset);
        check_eq("be_merge_lit", m_preset, 32'hAA22_3344);
        bus_write(A_COUNT, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_COUNT, got); check_eq("count_ro", got, 32'h0);
        bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_RSVD, got); check_eq("rsvd_ro", got, 32'h0);
        bus_write(A_PRESET + 32'h100, 32'h5555_5555, 4'hF);
        bus_read(A_PRESET, got); check_eq("unsel_wr", got, 32'hAA22_3344);
        bus_read(BASE + 32'h10, got); check_eq("unsel_rd", got, 32'h0);
        bus_write(A_CTRL, 32'hFFFF_FFF0, 4'hF);
        bus_read(A_CTRL, got); check_eq("ctrl_hi_bits", got, 32'h0);
        bus_write(A_CTRL, 32'h0000_000F, 4'b1110);
        bus_read(A_CTRL, got); check_eq("ctrl_lane0_off", got, 32'h0);
        junk = $urandom;
        @(negedge clk);
        addr   = A_PRESET;
        byteen = 4'b0010;
        wdata  = junk;
        #1;
        check_eq("rd_during_wr", rdata, m_preset);
        @(posedge clk);
        #1;
        addr   = '0;
        byteen = '0;
        wdata  = '0;
        model_write(A_PRESET, junk, 4'b0010);
        bus_read(A_PRESET, got); check_eq("be_lane1", got, m_preset);

        // One-shot: irq 7 edges after enable, EN self-clears, CTRL write drops irq
        do_reset();
        bus_write(A_PRESET, 32'd5, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'h1);
        check_run(10, 0, 1'b1, 1'b0, -1, 0);
        bus_write(A_CTRL, 32'h0, 4'hF);
        check_eq("oneshot_ctrl_clr", 32'(irq), 32'h0);

        // One-shot flag cleared by a PRESET write while IM stays set
        do_reset();
        bus_write(A_PRESET, 32'd1, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'h1);
        check_run(5, 0, 1'b1, 1'b0, -1, 0);
        bus_write(A_PRESET, 32'd7, 4'hF);
        check_eq("oneshot_preset_clr", 32'(irq), 32'h0);

        // Auto-reload, masked and unmasked
        do_reset();
        bus_write(A_PRESET, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'hB, 4'h1);
        check_run(23, 0, 1'b1, 1'b1, -1, 0);
        do_reset();
        bus_write(A_PRESET, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'h3, 4'h1);
        check_run(15, 0, 1'b0, 1'b1, -1, 0);

        // PRESET=0 acts like 1; PRESET write mid-count only affects the next load
        do_reset();
        bus_write(A_CTRL, 32'hB, 4'h1);
        check_run(12, 0, 1'b1, 1'b1, -1, 0);
        do_reset();
        bus_write(A_PRESET, 32'd8, 4'hF);
        bus_write(A_CTRL, 32'hB, 4'h1);
        check_run(30, 0, 1'b1, 1'b1, 4, 32'd2);

        // Pause at COUNT=10, hold, then restart from a new PRESET
        do_reset();
        bus_write(A_PRESET, 32'd20, 4'hF);
        bus_write(A_CTRL, 32'h1, 4'h1);
        repeat (11) tick();
        bus_write(A_CTRL, 32'h0, 4'h1);
        for (int i = 0; i < 20; i++) begin
            bus_read(A_COUNT, got);
            check_eq("pause_hold", got, 32'd10);
            tick();
        end
        bus_write(A_PRESET, 32'd4, 4'hF);
        bus_write(A_CTRL, 32'h1, 4'h1);
        check_run(8, 10, 1'b0, 1'b0, -1, 0);

        // INT-state EN clear collides with a CTRL write: bus value wins
        do_reset();
        bus_write(A_PRESET, 32'd2, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'h1);
        repeat (4) tick();
        check_eq("coll_irq_rise", 32'(irq), 32'h1);
        bus_write(A_CTRL, 32'h9, 4'h1);
        bus_read(A_CTRL, got); check_eq("coll_ctrl", got, 32'h9);
        check_eq("coll_irq", 32'(irq), 32'h0);

        // Asynchronous reset mid-count
        do_reset();
        bus_write(A_PRESET, 32'd20, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'h1);
        repeat (15) tick();
        bus_read(A_COUNT, got); check_eq("pre_areset_count", got, 32'd7);
        #1;
        reset = 1'b0;
        #1;
        bus_read(A_COUNT, got);  check_eq("areset_count", got, 32'h0);
        bus_read(A_CTRL, got);   check_eq("areset_ctrl", got, 32'h0);
        bus_read(A_PRESET, got); check_eq("areset_preset", got, 32'h0);
        check_eq("areset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset    = 1'b1;
        m_ctrl   = '0;
        m_preset = '0;
        repeat (3) begin
            tick();
            bus_read(A_COUNT, got);
            check_eq("post_areset_idle", got, 32'h0);
        end
        bus_write(A_PRESET, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'h1);
        check_run(7, 0, 1'b1, 1'b0, -1, 0);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            do_reset();
            n       = $urandom_range(0, 12);
            mode    = $urandom_range(0, 3);
            im      = $urandom_range(0, 1);
            mid_val = $urandom_range(0, 6);
            mid_k   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 + ((n < 1) ? 1 : n)) : -1;
            auto_m  = (mode == 1);
            junk    = $urandom;
            bus_write(A_PRESET, 32'(n), 4'hF);
            bus_write(A_CTRL, {junk[27:0], im[0], mode[1:0], 1'b1}, 4'hF);
            check_run(auto_m ? 40 : 20, 0, im[0], auto_m, mid_k, 32'(mid_val));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
